// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants.
// Used by uart_tx and intended for reuse by uart_rx once it supports parity.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSync   = 3'd1,
    StStart  = 3'd2,
    StData   = 3'd3,
    StParity = 3'd4,
    StStop   = 3'd5
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Parity bit for a byte under the given mode; none yields 0.
  function automatic logic calc_parity(input logic [7:0] data, input int unsigned mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      p = ~p;
    end else if (mode == PAR_NONE) begin
      p = 1'b0;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a requester and uart_tx: data bus plus valid/ready.
interface uart_tx_if;

  logic [7:0] uart_tx_data_bus;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output uart_tx_data_bus,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  uart_tx_data_bus,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Bit timing follows an external one-cycle baud tick shared with the receiver.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       T_byte,
  uart_tx_if.slave   bus,
  output logic       Serial_out,
  output logic       uart_tx_busy,
  output logic       uart_tx_done
);

  if (PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic StopLast  = (STOP_BITS == 2);
  localparam logic HasParity = (PARITY != PAR_NONE);

  uart_state_e r_state, w_state_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic        r_stop_cnt, w_stop_cnt_nxt;
  logic        r_par, w_par_nxt;
  logic        r_serial, w_serial_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        w_ready;
  logic        w_accept;

  assign w_ready      = (r_state == StIdle);
  assign w_accept     = bus.tx_valid && w_ready;
  assign bus.tx_ready = w_ready;

  assign Serial_out   = r_serial;
  assign uart_tx_busy = r_busy;
  assign uart_tx_done = r_done;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_serial   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_par      <= w_par_nxt;
      r_serial   <= w_serial_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_par_nxt      = r_par;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = StSync;
          w_shift_nxt = bus.uart_tx_data_bus;
          w_par_nxt   = calc_parity(bus.uart_tx_data_bus, PARITY);
        end
      end
      StSync: begin
        if (T_byte) begin
          w_state_nxt    = StStart;
          w_bit_cnt_nxt  = 3'd0;
          w_stop_cnt_nxt = 1'b0;
        end
      end
      StStart: begin
        if (T_byte) begin
          w_state_nxt = StData;
        end
      end
      StData: begin
        if (T_byte) begin
          if (r_bit_cnt != 3'd7) begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end else if (HasParity) begin
            w_state_nxt = StParity;
          end else begin
            w_state_nxt = StStop;
          end
        end
      end
      StParity: begin
        if (T_byte) begin
          w_state_nxt = StStop;
        end
      end
      StStop: begin
        if (T_byte) begin
          if (r_stop_cnt == StopLast) begin
            w_state_nxt = StIdle;
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    w_busy_nxt = (w_state_nxt != StIdle);
    w_done_nxt = (r_state == StStop) && (w_state_nxt == StIdle);
    case (w_state_nxt)
      StStart:  w_serial_nxt = 1'b0;
      StData:   w_serial_nxt = w_shift_nxt[0];
      StParity: w_serial_nxt = w_par_nxt;
      default:  w_serial_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover no parity/1 stop, even/2 stop, odd/2 stop.
module tb_uart_tx;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] bits;  // line value per tick period, first period at bit 11
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] data;
  logic [2:0] valid;
  logic [2:0] ser;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] ready;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   tcnt;
  logic tick_at_edge;
  int   done_cnt0 = 0;

  always #5 clk = ~clk;

  uart_tx_if bus0 ();
  uart_tx_if bus1 ();
  uart_tx_if bus2 ();

  assign bus0.uart_tx_data_bus = data;
  assign bus1.uart_tx_data_bus = data;
  assign bus2.uart_tx_data_bus = data;
  assign bus0.tx_valid = valid[0];
  assign bus1.tx_valid = valid[1];
  assign bus2.tx_valid = valid[2];
  assign ready[0] = bus0.tx_ready;
  assign ready[1] = bus1.tx_ready;
  assign ready[2] = bus2.tx_ready;

  uart_tx #(.PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clock(clk), .reset(rst), .T_byte(tick), .bus(bus0),
    .Serial_out(ser[0]), .uart_tx_busy(busy[0]), .uart_tx_done(done[0])
  );
  uart_tx #(.PARITY(1), .STOP_BITS(2)) u_dut1 (
    .clock(clk), .reset(rst), .T_byte(tick), .bus(bus1),
    .Serial_out(ser[1]), .uart_tx_busy(busy[1]), .uart_tx_done(done[1])
  );
  uart_tx #(.PARITY(2), .STOP_BITS(2)) u_dut2 (
    .clock(clk), .reset(rst), .T_byte(tick), .bus(bus2),
    .Serial_out(ser[2]), .uart_tx_busy(busy[2]), .uart_tx_done(done[2])
  );

  always @(negedge clk) begin
    if (done[0] === 1'b1) done_cnt0++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  // One clock; tick is high for exactly one edge in every 16.
  task automatic cyc();
    @(posedge clk);
    tick_at_edge = tick;
    #1;
    tcnt = (tcnt + 1) % 16;
    tick = (tcnt == 0);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!tick_at_edge && n < 40);
    if (!tick_at_edge) timeout("wait_tick");
  endtask

  // Starts just after the accept edge; checks SYNC, every bit period and the done edge.
  task automatic check_frame(input int sel, input logic [11:0] bits, input int nbits,
                             input bit noise);
    logic sync_ok = 1'b1;
    int   n = 0;
    do begin
      cyc();
      n++;
      if (!tick_at_edge && ser[sel] !== 1'b1) sync_ok = 1'b0;
    end while (!tick_at_edge && n < 40);
    if (!tick_at_edge) timeout("sync_tick");
    chk($sformatf("sync_high_dut%0d", sel), 32'(sync_ok), 32'd1);
    for (int k = 0; k < nbits; k++) begin
      if (k > 0) wait_tick();
      repeat (8) cyc();
      chk($sformatf("bit%0d_dut%0d", k, sel), 32'(ser[sel]), 32'(bits[11-k]));
      chk($sformatf("busy_bit%0d_dut%0d", k, sel), 32'(busy[sel]), 32'd1);
      chk($sformatf("nodone_bit%0d_dut%0d", k, sel), 32'(done[sel]), 32'd0);
      if (noise && k == 4) begin
        data = ~data;
        valid[sel] = 1'b1;
        cyc();
        valid[sel] = 1'b0;
      end
    end
    wait_tick();
    chk($sformatf("done_dut%0d", sel), 32'(done[sel]), 32'd1);
    chk($sformatf("ready_at_done_dut%0d", sel), 32'(ready[sel]), 32'd1);
    chk($sformatf("idle_busy_dut%0d", sel), 32'(busy[sel]), 32'd0);
    chk($sformatf("idle_line_dut%0d", sel), 32'(ser[sel]), 32'd1);
    cyc();
    chk($sformatf("done_pulse_end_dut%0d", sel), 32'(done[sel]), 32'd0);
  endtask

  task automatic send(input int sel, input logic [7:0] byte_in, input logic [11:0] bits,
                      input int nbits, input bit noise);
    wait_tick();
    repeat (3) cyc();
    data = byte_in;
    valid[sel] = 1'b1;
    cyc();
    valid[sel] = 1'b0;
    chk($sformatf("accept_busy_dut%0d", sel), 32'(busy[sel]), 32'd1);
    chk($sformatf("accept_ready_dut%0d", sel), 32'(ready[sel]), 32'd0);
    check_frame(sel, bits, nbits, noise);
  endtask

  initial begin
    vec_t vecs[5];
    int   n;
    int   m;
    int   saved;

    vecs[0] = '{sel: 0, data: 8'hA5, nbits: 10, bits: 12'b010100101100};
    vecs[1] = '{sel: 1, data: 8'hA5, nbits: 12, bits: 12'b010100101011};
    vecs[2] = '{sel: 2, data: 8'hA5, nbits: 12, bits: 12'b010100101111};
    vecs[3] = '{sel: 1, data: 8'h01, nbits: 12, bits: 12'b010000000111};
    vecs[4] = '{sel: 2, data: 8'h00, nbits: 12, bits: 12'b000000000111};

    rst   = 1'b1;
    tick  = 1'b0;
    tcnt  = 1;
    valid = 3'b000;
    data  = 8'h00;
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_line_dut%0d", i), 32'(ser[i]), 32'd1);
      chk($sformatf("rst_busy_dut%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_done_dut%0d", i), 32'(done[i]), 32'd0);
      chk($sformatf("rst_ready_dut%0d", i), 32'(ready[i]), 32'd1);
    end
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      send(vecs[v].sel, vecs[v].data, vecs[v].bits, vecs[v].nbits, 1'b1);
    end

    // Back-to-back with valid held: 0x00 then 0xFF, second accept right after done.
    wait_tick();
    repeat (3) cyc();
    data = 8'h00;
    valid[0] = 1'b1;
    cyc();
    data = 8'hFF;
    chk("b2b_first_busy", 32'(busy[0]), 32'd1);
    check_frame(0, 12'b000000000100, 10, 1'b0);
    chk("b2b_second_accept", 32'(busy[0]), 32'd1);
    valid[0] = 1'b0;
    check_frame(0, 12'b011111111100, 10, 1'b0);

    // Accept on a tick edge: that tick is ignored, start bit spans one full period.
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    data = 8'h01;
    valid[0] = 1'b1;
    cyc();
    valid[0] = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (ser[0] === 1'b1 && n < 40);
    chk("coinc_sync_cycles", 32'(n), 32'd16);
    m = 1;
    while (m < 40) begin
      cyc();
      if (ser[0] !== 1'b0) break;
      m++;
    end
    chk("coinc_start_cycles", 32'(m), 32'd16);
    n = 0;
    while (done[0] !== 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    if (done[0] !== 1'b1) timeout("coinc_done");
    cyc();

    // Reset during data bit 3 aborts the frame with no done pulse.
    wait_tick();
    repeat (3) cyc();
    data = 8'h55;
    valid[0] = 1'b1;
    cyc();
    valid[0] = 1'b0;
    repeat (5) wait_tick();
    repeat (4) cyc();
    saved = done_cnt0;
    rst = 1'b1;
    cyc();
    chk("midrst_line", 32'(ser[0]), 32'd1);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_ready", 32'(ready[0]), 32'd1);
    rst = 1'b0;
    repeat (120) cyc();
    chk("midrst_no_done", 32'(done_cnt0), 32'(saved));
    chk("midrst_line_idle", 32'(ser[0]), 32'd1);
    send(0, 8'h3C, 12'b000111100100, 10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
